// File: rtl/fifo_read_packer.sv
// fifo_read_packer: packs BEATS show-ahead FIFO entries into one registered valid/ready word
module fifo_read_packer #(
    parameter int WIDTH = 4,
    parameter int BEATS = 2,
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   empty,
    output logic                   re,
    input  logic [WIDTH-1:0]       rdata,
    input  logic                   clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH*BEATS-1:0] out_data,
    output logic [CW-1:0]          beat_cnt
);
    logic last;
    logic slot_free;
    logic [WIDTH*BEATS-1:0] next_word;

    assign slot_free = ~out_valid | out_ready;
    assign re = rst_n & ~empty & ~clear & (~last | slot_free);

    if (BEATS > 1) begin : g_acc
        logic [BEATS-2:0][WIDTH-1:0] acc;
        assign last = (beat_cnt == CW'(BEATS - 1));
        assign next_word = {rdata, acc};
        // Non-final beats fill accumulator slots; clear only rewinds the count
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                acc      <= '0;
                beat_cnt <= '0;
            end else if (clear) begin
                beat_cnt <= '0;
            end else if (re) begin
                if (!last)
                    acc[beat_cnt] <= rdata;
                beat_cnt <= last ? '0 : beat_cnt + CW'(1);
            end
        end
    end else begin : g_direct
        assign last = 1'b1;
        assign next_word = rdata;
        assign beat_cnt = '0;
    end

    // Final pop loads a complete word; acceptance without a new word drops valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (re && last) begin
            out_valid <= 1'b1;
            out_data  <= next_word;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_read_packer.sv
// tb_fifo_read_packer: directed scoreboard bench for the 2-beat and 1-beat packers
module tb_fifo_read_packer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       empty, clear, out_ready, re, out_valid;
    logic [3:0] rdata;
    logic [7:0] out_data;
    logic [0:0] beat_cnt;
    logic       empty1, clear1, out_ready1, re1, out_valid1;
    logic [3:0] rdata1, out_data1;
    logic [0:0] beat_cnt1;

    int checks = 0;
    int failures = 0;
    logic [3:0] fq[$];
    logic [3:0] fq1[$];
    logic [7:0] exp_q[$];
    logic [3:0] exp1_q[$];

    fifo_read_packer #(.WIDTH(4), .BEATS(2)) dut (
        .clk(clk), .rst_n(rst_n), .empty(empty), .re(re), .rdata(rdata), .clear(clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .beat_cnt(beat_cnt)
    );

    fifo_read_packer #(.WIDTH(4), .BEATS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .empty(empty1), .re(re1), .rdata(rdata1), .clear(clear1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .beat_cnt(beat_cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        empty  = (fq.size() == 0);
        rdata  = empty ? 4'h0 : fq[0];
        empty1 = (fq1.size() == 0);
        rdata1 = empty1 ? 4'h0 : fq1[0];
    endtask

    task automatic push(input logic [3:0] v);
        fq.push_back(v);
        refresh();
    endtask

    task automatic push1(input logic [3:0] v);
        fq1.push_back(v);
        refresh();
    endtask

    // One clock: sample pops before the edge, retire popped entries after it
    task automatic step();
        logic p, p1;
        #1;
        p = re;
        p1 = re1;
        @(posedge clk);
        #1;
        if (p && fq.size() > 0) void'(fq.pop_front());
        if (p1 && fq1.size() > 0) void'(fq1.pop_front());
        refresh();
    endtask

    // Monitor: a word presented with ready high is consumed at the next edge
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL word2: unexpected word 0x%0h expected none", out_data);
            end else begin
                chk("word2", {24'h0, out_data}, {24'h0, exp_q.pop_front()});
            end
        end
        if (rst_n && out_valid1 && out_ready1) begin
            if (exp1_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL word1: unexpected word 0x%0h expected none", out_data1);
            end else begin
                chk("word1", {28'h0, out_data1}, {28'h0, exp1_q.pop_front()});
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        clear1 = 1'b0;
        out_ready = 1'b1;
        out_ready1 = 1'b1;
        refresh();
        repeat (2) step();
        chk("rst_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_data", {24'h0, out_data}, 32'h0);
        chk("rst_cnt", {31'h0, beat_cnt}, 32'h0);
        rst_n = 1'b1;
        step();

        // 1: single word 0xA3
        push(4'h3);
        push(4'hA);
        exp_q.push_back(8'hA3);
        #1 chk("t1_re0", {31'h0, re}, 32'h1);
        step();
        chk("t1_cnt1", {31'h0, beat_cnt}, 32'h1);
        chk("t1_re1", {31'h0, re}, 32'h1);
        step();
        chk("t1_valid", {31'h0, out_valid}, 32'h1);
        chk("t1_data", {24'h0, out_data}, 32'hA3);
        chk("t1_cnt0", {31'h0, beat_cnt}, 32'h0);
        step();
        chk("t1_drop", {31'h0, out_valid}, 32'h0);

        // 2: continuous stream, re never low
        for (int i = 1; i <= 8; i++) push(4'(i));
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h43);
        exp_q.push_back(8'h65);
        exp_q.push_back(8'h87);
        for (int i = 0; i < 8; i++) begin
            #1 chk("t2_re", {31'h0, re}, 32'h1);
            step();
        end
        chk("t2_last", {24'h0, out_data}, 32'h87);
        step();

        // 3: stall after 0x21, then resume back-to-back
        for (int i = 1; i <= 4; i++) push(4'(i));
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h43);
        step();
        step();
        out_ready = 1'b0;
        step();
        repeat (2) begin
            #1 chk("t3_re_stall", {31'h0, re}, 32'h0);
            chk("t3_empty", {31'h0, empty}, 32'h0);
            chk("t3_cnt", {31'h0, beat_cnt}, 32'h1);
            chk("t3_hold", {24'h0, out_data}, 32'h21);
            chk("t3_valid", {31'h0, out_valid}, 32'h1);
            step();
        end
        out_ready = 1'b1;
        #1 chk("t3_re_go", {31'h0, re}, 32'h1);
        step();
        chk("t3_b2b_valid", {31'h0, out_valid}, 32'h1);
        chk("t3_b2b_data", {24'h0, out_data}, 32'h43);
        step();

        // 4: clear discards 0x5
        push(4'h5);
        push(4'h6);
        push(4'h7);
        exp_q.push_back(8'h76);
        step();
        clear = 1'b1;
        #1 chk("t4_re_clr", {31'h0, re}, 32'h0);
        step();
        clear = 1'b0;
        chk("t4_cnt", {31'h0, beat_cnt}, 32'h0);
        step();
        step();
        chk("t4_data", {24'h0, out_data}, 32'h76);
        step();

        // 5: async reset with a pending word and one beat held
        out_ready = 1'b0;
        push(4'h8);
        push(4'h9);
        push(4'hA);
        push(4'hB);
        push(4'hC);
        repeat (3) step();
        chk("t5_pend", {24'h0, out_data}, 32'h98);
        chk("t5_cnt1", {31'h0, beat_cnt}, 32'h1);
        #1 rst_n = 1'b0;
        #1 chk("t5_valid", {31'h0, out_valid}, 32'h0);
        chk("t5_data", {24'h0, out_data}, 32'h0);
        chk("t5_cnt", {31'h0, beat_cnt}, 32'h0);
        chk("t5_re", {31'h0, re}, 32'h0);
        step();
        chk("t5_keep", fq.size(), 32'd2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        exp_q.push_back(8'hCB);
        step();
        step();
        chk("t5_fresh", {24'h0, out_data}, 32'hCB);
        step();

        // 6: single-beat packer with toggling ready
        push1(4'h9);
        push1(4'hC);
        exp1_q.push_back(4'h9);
        exp1_q.push_back(4'hC);
        out_ready1 = 1'b0;
        step();
        chk("t6_data9", {28'h0, out_data1}, 32'h9);
        #1 chk("t6_re_stall", {31'h0, re1}, 32'h0);
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        chk("t6_dataC", {28'h0, out_data1}, 32'hC);
        step();
        chk("t6_holdC", {31'h0, out_valid1}, 32'h1);
        out_ready1 = 1'b1;
        step();
        step();
        chk("t6_cnt", {31'h0, beat_cnt1}, 32'h0);

        chk("sb_left2", exp_q.size(), 32'd0);
        chk("sb_left1", exp1_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
